// File: rtl/hb_phase_decoder_if.sv
// Coil-bus monitor interface between the stepper driver side and the phase decoder.
//   hb_in, clr          : driver-side inputs (master drives, decoder samples)
//   position, cycles    : signed wrapping phase / full-sequence counters
//   dir, moving         : direction of last valid step, motion status
//   *_pulse             : one-cycle event strobes
//   err_sticky/err_count: sequence-error history
interface hb_phase_decoder_if #(
  parameter int unsigned POS_W = 32,
  parameter int unsigned ERR_W = 8
);
  logic [3:0]       hb_in;
  logic             clr;
  logic [POS_W-1:0] position;
  logic [POS_W-1:0] cycles;
  logic             dir;
  logic             moving;
  logic             step_pulse;
  logic             cycle_pulse;
  logic             done_pulse;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;

  modport master (
    output hb_in, clr,
    input  position, cycles, dir, moving, step_pulse, cycle_pulse,
           done_pulse, err_pulse, err_sticky, err_count
  );

  modport slave (
    input  hb_in, clr,
    output position, cycles, dir, moving, step_pulse, cycle_pulse,
           done_pulse, err_pulse, err_sticky, err_count
  );
endinterface

// File: rtl/hb_phase_decoder.sv
// Passive decoder of the full-step H-bridge phase sequence.
// Ports:
//   clk     : system clock, rising edge
//   PRESERN : synchronous active-high reset
//   bus     : hb_phase_decoder_if.slave (coil bus in, position/status/errors out)
// All outputs are registered; they reflect a bus change one clock after it appears.
module hb_phase_decoder #(
  parameter int unsigned POS_W        = 32,
  parameter int unsigned ERR_W        = 8,
  parameter int unsigned STALL_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              PRESERN,
  hb_phase_decoder_if.slave bus
);

  localparam int unsigned IDLE_W = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALL_CYCLES - 1);
  localparam logic [3:0] HB_OFF = 4'b0000;

  logic [3:0]        hb_q;
  logic [POS_W-1:0]  position_q, position_d;
  logic [POS_W-1:0]  cycles_q, cycles_d;
  logic              dir_q, dir_d;
  logic              moving_q, moving_d;
  logic              step_q, step_d;
  logic              cyc_q, cyc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [ERR_W-1:0]  errcnt_q, errcnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic              prev_vld, cur_vld, illegal;
  logic [1:0]        prev_idx, cur_idx, delta;

  // Map a phase code to its position in the forward sequence; {valid, index}.
  function automatic logic [2:0] phase_idx(input logic [3:0] code);
    case (code)
      4'b1001: phase_idx = 3'b100;
      4'b0101: phase_idx = 3'b101;
      4'b0110: phase_idx = 3'b110;
      4'b1010: phase_idx = 3'b111;
      default: phase_idx = 3'b000;
    endcase
  endfunction

  // Transition classifier and next-state computation.
  always_comb begin
    position_d = position_q;
    cycles_d   = cycles_q;
    dir_d      = dir_q;
    moving_d   = moving_q;
    step_d     = 1'b0;
    cyc_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sticky_d   = sticky_q;
    errcnt_d   = errcnt_q;
    idle_d     = idle_q;
    illegal    = 1'b0;

    {prev_vld, prev_idx} = phase_idx(hb_q);
    {cur_vld, cur_idx}   = phase_idx(bus.hb_in);
    // Modulo-4 distance along the forward sequence: 1 = forward, 3 = reverse, 2 = skipped step.
    delta = cur_idx - prev_idx;

    if (bus.hb_in == hb_q) begin
      // Holding a phase: count idle cycles until the stall threshold drops moving.
      if (prev_vld) begin
        if (idle_q == IDLE_MAX) moving_d = 1'b0;
        else                    idle_d   = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
      if (cur_vld) begin
        if (!prev_vld) begin
          moving_d = 1'b1;
        end else begin
          case (delta)
            2'd1: begin
              position_d = position_q + POS_W'(1);
              dir_d      = 1'b1;
              step_d     = 1'b1;
              moving_d   = 1'b1;
              if (prev_idx == 2'd3) begin
                cycles_d = cycles_q + POS_W'(1);
                cyc_d    = 1'b1;
              end
            end
            2'd3: begin
              position_d = position_q - POS_W'(1);
              dir_d      = 1'b0;
              step_d     = 1'b1;
              moving_d   = 1'b1;
              if (prev_idx == 2'd0) begin
                cycles_d = cycles_q - POS_W'(1);
                cyc_d    = 1'b1;
              end
            end
            default: illegal = 1'b1;
          endcase
        end
      end else if (bus.hb_in == HB_OFF) begin
        moving_d = 1'b0;
        done_d   = prev_vld;
      end else begin
        illegal  = 1'b1;
        moving_d = 1'b0;
      end

      if (illegal) begin
        err_d    = 1'b1;
        sticky_d = 1'b1;
        if (!(&errcnt_q)) errcnt_d = errcnt_q + ERR_W'(1);
      end
    end

    // Clear overrides any same-cycle count or error update; pulses/dir/moving still follow.
    if (bus.clr) begin
      position_d = '0;
      cycles_d   = '0;
      errcnt_d   = '0;
      sticky_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (PRESERN) begin
      hb_q       <= HB_OFF;
      position_q <= '0;
      cycles_q   <= '0;
      dir_q      <= 1'b1;
      moving_q   <= 1'b0;
      step_q     <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      errcnt_q   <= '0;
      idle_q     <= '0;
    end else begin
      hb_q       <= bus.hb_in;
      position_q <= position_d;
      cycles_q   <= cycles_d;
      dir_q      <= dir_d;
      moving_q   <= moving_d;
      step_q     <= step_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      errcnt_q   <= errcnt_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.position    = position_q;
  assign bus.cycles      = cycles_q;
  assign bus.dir         = dir_q;
  assign bus.moving      = moving_q;
  assign bus.step_pulse  = step_q;
  assign bus.cycle_pulse = cyc_q;
  assign bus.done_pulse  = done_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.err_count   = errcnt_q;

endmodule

// File: doc/hb_phase_decoder.md
Name: hb_phase_decoder

Overview:
- Passive monitor on the 4-bit H-bridge coil bus produced by the stepper driver; it is the receiving end of the full-step phase sequence.
- Decodes phase transitions into:
  - a signed phase position;
  - a signed full-cycle count;
  - direction and motion status;
  - sequence-error reporting.
- Sits beside the driver in the same clock domain and feeds closed-loop position checks and debug registers.

Parameters:
- POS_W, 32, width of position and cycles counters (two's complement, wrapping)
- ERR_W, 8, width of saturating error counter
- STALL_CYCLES, 1000, consecutive cycles without a phase change before moving drops; must be >= 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- PRESERN  input  1  synchronous reset, active-high
- hb_in  input  4  coil drive state from the H-bridge driver, synchronous to clk
- clr  input  1  synchronous clear of position, cycles, err_sticky, err_count
- position  output  POS_W  signed phase count: +1 per forward phase step, -1 per reverse step
- cycles  output  POS_W  signed full-sequence count
- dir  output  1  direction of last valid step: 1 = forward, 0 = reverse
- moving  output  1  high while steps are arriving
- step_pulse  output  1  one-cycle pulse per valid phase step
- cycle_pulse  output  1  one-cycle pulse per full-cycle boundary
- done_pulse  output  1  one-cycle pulse when the bus returns to 0000 from a valid phase
- err_pulse  output  1  one-cycle pulse per illegal transition
- err_sticky  output  1  set on any illegal transition, held until clr or reset
- err_count  output  ERR_W  number of illegal transitions, saturating at all-ones

Behaviour:
- Valid codes:
  - OFF = 0000.
  - Phases, forward order: 1001 -> 0101 -> 0110 -> 1010 -> 1001.
  - Reverse order is the exact inverse.
  - All other 11 codes are INVALID.
- hb_q register holds the previous sample. It is updated every cycle with hb_in, including during clr; it is not updated during reset.
- Each edge classifies the pair (hb_q, hb_in). All outputs update on that same edge, so outputs reflect a bus change one clock after it appears.
- Transition classes (pulses are low unless stated):
  - Equal codes: no event. The idle counter increments (saturating) while hb_q is a phase.
  - OFF or INVALID -> phase (start): position unchanged, dir unchanged, moving=1, idle counter cleared.
  - Phase -> forward-next phase: position+1, dir=1, step_pulse=1, moving=1, idle cleared.
    - If the step is 1010 -> 1001: also cycles+1 and cycle_pulse=1.
  - Phase -> reverse-next phase: position-1, dir=0, step_pulse=1, moving=1, idle cleared.
    - If the step is 1001 -> 1010: also cycles-1 and cycle_pulse=1.
  - Phase -> opposite phase (1001<->0110, 0101<->1010), i.e. a skipped step:
    - illegal: err_pulse=1, err_sticky=1, err_count+1 (saturating);
    - position, cycles and dir unchanged;
    - moving unchanged; idle cleared.
  - Any -> INVALID (when different from hb_q): illegal exactly as above, moving=0.
  - Phase -> OFF: done_pulse=1, moving=0, position unchanged.
  - INVALID -> OFF: moving=0, no done_pulse, no error.
- Stall: when the idle counter reaches STALL_CYCLES-1 while hb_q is a phase, moving=0 on the next edge. A later valid step sets moving=1 again.
- Arithmetic: position and cycles wrap modulo 2^POS_W with no saturation. err_count holds at 2^ERR_W-1.
- clr:
  - Zeroes position, cycles, err_count and err_sticky on that edge.
  - Has priority over any same-cycle transition: increments and error sets from that cycle are discarded.
  - Pulses, dir and moving still update normally.
- Reset (PRESERN=1), priority over everything:
  - hb_q=0000, position=0, cycles=0, dir=1, moving=0, all pulses 0, err_sticky=0, err_count=0, idle=0.
- First edge after reset: if hb_in is a phase, it is treated as a start (no step counted).
- Reset mid-motion behaves identically; no history is retained.

Test Plan:
- Reset, hold hb_in=0000; then apply 1001,0101,0110,1010,1001,0101 one per cycle -> position=5, cycles=1, dir=1, five step_pulses, one cycle_pulse on the 1010->1001 edge.
- From 1001 apply 1010,0110,0101,1001,1010 -> position decreases by 5, cycles decreases by 2, dir=0.
- Apply 1001 then 0110 -> err_pulse 1 cycle, err_sticky=1, err_count=1, position unchanged. Apply 1111 -> err_count=2, moving=0.
- Apply 1001 then hold with STALL_CYCLES=4 -> moving falls exactly 4 cycles after the last change. Then apply 0101 -> moving=1 and position+1.
- Assert clr on the same cycle as a 0101->0110 step -> position=0, cycles=0, err_count=0, step_pulse=1, dir=1.
- Assert PRESERN mid-sequence with position=7 -> all outputs at reset values next edge. Release with hb_in=0110 -> no step counted; next 1010 -> position=1.
